// File: rtl/uart_rx_frame_ctrl.sv
// Parses SYNC/ADDR/DATA/CSUM write frames from the UART byte stream and commits
// them into a small register bank, with status pulses, error count and LED.
module uart_rx_frame_ctrl #(
  parameter int         CLK_FREQ       = 50000000,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         NUM_REGS       = 8,
  localparam int        AW             = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          frame_ok,
  output logic          frame_err,
  output logic [7:0]    err_count,
  output logic          busy,
  output logic          led
);
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // CLK_FREQ is informational only; catch nonsensical parameter sets early.
  if (CLK_FREQ <= 0 || TIMEOUT_CYCLES < 2 || NUM_REGS < 2 ||
      (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_params
    $error("uart_rx_frame_ctrl: invalid parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM} state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rx_valid_prev_q, rx_valid_prev_d;
  logic [7:0]    bank_q [NUM_REGS];
  logic [7:0]    bank_d [NUM_REGS];
  logic          wr_en_q, wr_en_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          led_q, led_d;

  logic accept;
  logic timeout_hit;
  logic frame_good;
  logic err_pulse;

  assign accept      = rx_valid & ~rx_valid_prev_q;
  assign timeout_hit = (to_cnt_q == TO_LAST);
  // rx_data here is the checksum byte; the address must fit the bank with no aliasing.
  assign frame_good  = (rx_data == (addr_q ^ data_q)) && ({24'd0, addr_q} < 32'(NUM_REGS));

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    data_d          = data_q;
    bank_d          = bank_q;
    rx_valid_prev_d = rx_valid;
    wr_en_d         = 1'b0;
    frame_ok_d      = 1'b0;
    err_pulse       = 1'b0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    led_d           = led_q;
    err_count_d     = err_count_q;
    to_cnt_d        = (state_q == S_IDLE || accept || timeout_hit) ? '0 : to_cnt_q + TW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (accept && rx_data == SYNC_BYTE) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (accept) begin
          addr_d  = rx_data;
          state_d = S_DATA;
        end else if (timeout_hit) begin
          state_d   = S_IDLE;
          err_pulse = 1'b1;
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d  = rx_data;
          state_d = S_CSUM;
        end else if (timeout_hit) begin
          state_d   = S_IDLE;
          err_pulse = 1'b1;
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = S_IDLE;
          if (frame_good) begin
            bank_d[addr_q[AW-1:0]] = data_q;
            wr_en_d    = 1'b1;
            frame_ok_d = 1'b1;
            wr_addr_d  = addr_q[AW-1:0];
            wr_data_d  = data_q;
            led_d      = ~led_q;
          end else begin
            err_pulse = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d   = S_IDLE;
          err_pulse = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    frame_err_d = err_pulse;
    if (err_pulse && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      data_q          <= '0;
      to_cnt_q        <= '0;
      rx_valid_prev_q <= 1'b0;
      wr_en_q         <= 1'b0;
      frame_ok_q      <= 1'b0;
      frame_err_q     <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      err_count_q     <= '0;
      led_q           <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      to_cnt_q        <= to_cnt_d;
      rx_valid_prev_q <= rx_valid_prev_d;
      wr_en_q         <= wr_en_d;
      frame_ok_q      <= frame_ok_d;
      frame_err_q     <= frame_err_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      err_count_q     <= err_count_d;
      led_q           <= led_d;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= bank_d[i];
    end
  end

  assign rd_data   = bank_q[rd_addr];
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;
  assign led       = led_q;
  assign busy      = (state_q != S_IDLE);

endmodule
